// File: rtl/byte_serial_add_ctrl_pkg.sv
// byte_add_pkg: shared width, FSM state type and counter-width helper for byte_serial_add_ctrl
package byte_add_pkg;
    localparam int BYTE_W = 8;
    typedef enum logic {ST_FIRST, ST_CHAIN} state_t;
    function automatic int cnt_w(input int max_bytes);
        return (max_bytes > 1) ? $clog2(max_bytes) : 1;
    endfunction
endpackage

// File: rtl/byte_serial_add_ctrl_if.sv
// byte_serial_add_ctrl_if: operand-byte input stream and sum-byte output stream
//   in_valid/in_ready/in_a/in_b/in_ci/in_last[/in_sub] : operand bytes, LSB first
//   out_valid/out_ready/out_s/out_co/out_last          : registered sum bytes
//   in_sub exists only when SUBTRACT_EN is defined
//   master = stream producer/consumer side, slave = the controller
interface byte_serial_add_ctrl_if;
    import byte_add_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] in_a;
    logic [BYTE_W-1:0] in_b;
    logic              in_ci;
    logic              in_last;
`ifdef SUBTRACT_EN
    logic              in_sub;
`endif
    logic              out_valid;
    logic              out_ready;
    logic [BYTE_W-1:0] out_s;
    logic              out_co;
    logic              out_last;

    modport master (
`ifdef SUBTRACT_EN
        output in_sub,
`endif
        output in_valid, in_a, in_b, in_ci, in_last, out_ready,
        input  in_ready, out_valid, out_s, out_co, out_last
    );

    modport slave (
`ifdef SUBTRACT_EN
        input  in_sub,
`endif
        input  in_valid, in_a, in_b, in_ci, in_last, out_ready,
        output in_ready, out_valid, out_s, out_co, out_last
    );
endinterface

// File: rtl/byte_serial_add_ctrl_adder8.sv
// adder8: 8-bit combinational adder with carry in/out
//   a, b : addends    ci : carry in    s : sum    co : carry out
module adder8 (
    output logic [7:0] s,
    output logic       co,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {8'd0, ci};
endmodule

// File: rtl/byte_serial_add_ctrl.sv
// byte_serial_add_ctrl: byte-serial multi-precision add controller around adder8
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : operand input stream and registered sum output stream (slave modport)
//   busy  : high while mid-word (ST_CHAIN)
//   err   : sticky, set when a word is truncated at MAX_BYTES
//   Optional macro SUBTRACT_EN adds in_sub and two's-complement subtraction.
module byte_serial_add_ctrl
    import byte_add_pkg::*;
#(
    parameter int MAX_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    byte_serial_add_ctrl_if.slave bus,
    output logic                  busy,
    output logic                  err
);
    localparam int CW = cnt_w(MAX_BYTES);
    localparam logic [CW-1:0] LAST_IDX = CW'(MAX_BYTES - 1);

    state_t            state, state_nx;
    logic [CW-1:0]     byte_cnt;
    logic              carry_q;
    logic              accept, first, at_max, last_eff;
    logic [BYTE_W-1:0] add_b, add_s;
    logic              add_ci, add_co;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign first        = state == ST_FIRST;
    assign at_max       = byte_cnt == LAST_IDX;
    assign last_eff     = bus.in_last || at_max;

`ifdef SUBTRACT_EN
    logic sub_q, sub_eff;
    // The mode is taken live from the port on the first byte, then from the latch.
    assign sub_eff = first ? bus.in_sub : sub_q;
    assign add_b   = sub_eff ? ~bus.in_b : bus.in_b;
    // Subtraction forces the +1 of the two's complement in place of in_ci.
    assign add_ci  = first ? (bus.in_sub || bus.in_ci) : carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sub_q <= 1'b0;
        else if (accept && first)
            sub_q <= bus.in_sub;
    end
`else
    assign add_b  = bus.in_b;
    assign add_ci = first ? bus.in_ci : carry_q;
`endif

    adder8 u_add (
        .s  (add_s),
        .co (add_co),
        .a  (bus.in_a),
        .b  (add_b),
        .ci (add_ci)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_FIRST;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = accept ? (last_eff ? ST_FIRST : ST_CHAIN) : state;
    end

    always_comb begin
        busy = state == ST_CHAIN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_s     <= '0;
            bus.out_co    <= 1'b0;
            bus.out_last  <= 1'b0;
            carry_q       <= 1'b0;
            byte_cnt      <= '0;
            err           <= 1'b0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_s     <= add_s;
            bus.out_co    <= last_eff && add_co;
            bus.out_last  <= last_eff;
            carry_q       <= add_co;
            byte_cnt      <= last_eff ? '0 : byte_cnt + CW'(1);
            if (at_max && !bus.in_last)
                err <= 1'b1;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule
